// File: rtl/mem_stage_if.sv
// EXE/MEM input bus, fetch-side redirect/stall controls and MEM/WB output bus
// of the memory-access stage.
`timescale 1ns/1ps
interface mem_stage_if;
    logic [132:0] in;
    logic         pcSrc;
    logic [31:0]  pcTarget;
    logic         flush;
    logic         stall;
    logic [70:0]  out;

    modport master (output in, input pcSrc, pcTarget, flush, stall, out);
    modport slave  (input in, output pcSrc, pcTarget, flush, stall, out);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: beq/j redirect, fixed-latency data RAM access
// with upstream stall, registered MEM/WB bus.
`timescale 1ns/1ps
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input logic        clk,
    input logic        clr,
    mem_stage_if.slave bus
);
    localparam int   CNT_W = $clog2(MEM_LAT) + 1;
    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic MULTI = (MEM_LAT > 1) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic        zero_s;
    logic        reg_write_s;
    logic        mem_to_reg_s;
    logic        mem_write_s;
    logic        branch_eq_s;
    logic        jump_s;
    logic [4:0]  write_reg_s;
    logic [31:0] alu_out_s;
    logic [31:0] write_data_s;
    logic [31:0] pc_branch_s;
    logic [25:0] pc_jump_s;
    logic        memop_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [70:0]      out_r;
    logic [70:0]      out_nxt_s;
    logic             load_req_s;
    logic             ram_we_s;

    logic        req_reg_write_r;
    logic        req_mem_to_reg_r;
    logic        req_mem_write_r;
    logic [4:0]  req_write_reg_r;
    logic [31:0] req_alu_out_r;
    logic [31:0] req_write_data_r;

    logic              acc_reg_write_s;
    logic              acc_mem_to_reg_s;
    logic              acc_mem_write_s;
    logic [4:0]        acc_write_reg_s;
    logic [31:0]       acc_alu_out_s;
    logic [31:0]       acc_write_data_s;
    logic [ADDR_W-1:0] acc_idx_s;
    logic [70:0]       done_out_s;

    logic        redirect_s;
    logic [31:0] pc_target_s;
    logic        stall_s;

    logic [31:0] ram_r [DEPTH];

    assign zero_s       = bus.in[0];
    assign reg_write_s  = bus.in[1];
    assign mem_to_reg_s = bus.in[2];
    assign mem_write_s  = bus.in[3];
    assign branch_eq_s  = bus.in[4];
    assign jump_s       = bus.in[5];
    assign write_reg_s  = bus.in[10:6];
    assign alu_out_s    = bus.in[42:11];
    assign write_data_s = bus.in[74:43];
    assign pc_branch_s  = bus.in[106:75];
    assign pc_jump_s    = bus.in[132:107];
    assign memop_s      = mem_to_reg_s | mem_write_s;

    // Access fields: captured request while busy, live bus for a single-cycle access.
    always_comb begin
        acc_reg_write_s  = reg_write_s;
        acc_mem_to_reg_s = mem_to_reg_s;
        acc_mem_write_s  = mem_write_s;
        acc_write_reg_s  = write_reg_s;
        acc_alu_out_s    = alu_out_s;
        acc_write_data_s = write_data_s;
        if (state_r == BUSY) begin
            acc_reg_write_s  = req_reg_write_r;
            acc_mem_to_reg_s = req_mem_to_reg_r;
            acc_mem_write_s  = req_mem_write_r;
            acc_write_reg_s  = req_write_reg_r;
            acc_alu_out_s    = req_alu_out_r;
            acc_write_data_s = req_write_data_r;
        end else begin
            acc_reg_write_s  = reg_write_s;
        end
    end

    // Word address wraps: byte offset and bits above the RAM range are dropped.
    assign acc_idx_s  = acc_alu_out_s[ADDR_W+1:2];
    assign done_out_s = {(acc_mem_write_s ? 32'h0000_0000 : ram_r[acc_idx_s]),
                         acc_alu_out_s, acc_write_reg_s, acc_mem_to_reg_s, acc_reg_write_s};

    // Next-state, counter and MEM/WB bus selection.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        out_nxt_s   = out_r;
        load_req_s  = 1'b0;
        ram_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!memop_s) begin
                    out_nxt_s = {32'h0000_0000, alu_out_s, write_reg_s, mem_to_reg_s, reg_write_s};
                end else if (!MULTI) begin
                    ram_we_s  = acc_mem_write_s;
                    out_nxt_s = done_out_s;
                end else begin
                    load_req_s  = 1'b1;
                    cnt_nxt_s   = CNT_W'(MEM_LAT - 1);
                    out_nxt_s   = {71{1'b0}};
                    state_nxt_s = BUSY;
                end
            end
            BUSY: begin
                if (cnt_r > CNT_W'(1)) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                    out_nxt_s = {71{1'b0}};
                end else begin
                    ram_we_s    = acc_mem_write_s;
                    out_nxt_s   = done_out_s;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                out_nxt_s   = {71{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Redirect and stall; redirect is only meaningful while the stage is accepting input.
    always_comb begin
        redirect_s  = 1'b0;
        pc_target_s = 32'h0000_0000;
        stall_s     = 1'b0;
        if (state_r == IDLE) begin
            redirect_s  = jump_s | (branch_eq_s & zero_s);
            pc_target_s = jump_s ? {4'b0000, pc_jump_s, 2'b00} : pc_branch_s;
            stall_s     = memop_s & MULTI;
        end else begin
            stall_s     = (cnt_r > CNT_W'(1)) ? 1'b1 : 1'b0;
        end
    end

    // FSM, counter, request capture and registered MEM/WB bus.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r          <= IDLE;
            cnt_r            <= {CNT_W{1'b0}};
            out_r            <= {71{1'b0}};
            req_reg_write_r  <= 1'b0;
            req_mem_to_reg_r <= 1'b0;
            req_mem_write_r  <= 1'b0;
            req_write_reg_r  <= 5'd0;
            req_alu_out_r    <= 32'h0000_0000;
            req_write_data_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            out_r   <= out_nxt_s;
            if (load_req_s) begin
                req_reg_write_r  <= reg_write_s;
                req_mem_to_reg_r <= mem_to_reg_s;
                req_mem_write_r  <= mem_write_s;
                req_write_reg_r  <= write_reg_s;
                req_alu_out_r    <= alu_out_s;
                req_write_data_r <= write_data_s;
            end
        end
    end

    // Data RAM write port; contents survive clr, and an aborted access never reaches here.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[acc_idx_s] <= acc_write_data_s;
        end
    end

    assign bus.out      = out_r;
    assign bus.pcSrc    = redirect_s;
    assign bus.flush    = redirect_s;
    assign bus.pcTarget = pc_target_s;
    assign bus.stall    = stall_s;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage at MEM_LAT = 1, 2 and 3 against
// a word-array memory model and cycle-count rules.
`timescale 1ns/1ps
module tb_mem_stage;
    logic clk;
    logic clr;
    int   checks;
    int   failures;

    logic [132:0] stim [3];
    logic [70:0]  outv [3];
    logic         ps   [3];
    logic         fl   [3];
    logic         st   [3];
    logic [31:0]  pt   [3];

    logic [31:0] mdl [3][256];
    bit          vld [3][256];

    mem_stage_if bus0 ();
    mem_stage_if bus1 ();
    mem_stage_if bus2 ();

    assign bus0.in = stim[0];
    assign bus1.in = stim[1];
    assign bus2.in = stim[2];
    assign outv[0] = bus0.out;
    assign outv[1] = bus1.out;
    assign outv[2] = bus2.out;
    assign ps[0] = bus0.pcSrc;
    assign ps[1] = bus1.pcSrc;
    assign ps[2] = bus2.pcSrc;
    assign fl[0] = bus0.flush;
    assign fl[1] = bus1.flush;
    assign fl[2] = bus2.flush;
    assign st[0] = bus0.stall;
    assign st[1] = bus1.stall;
    assign st[2] = bus2.stall;
    assign pt[0] = bus0.pcTarget;
    assign pt[1] = bus1.pcTarget;
    assign pt[2] = bus2.pcTarget;

    mem_stage #(.ADDR_W(8), .MEM_LAT(1)) u_lat1 (.clk(clk), .clr(clr), .bus(bus0));
    mem_stage #(.ADDR_W(8), .MEM_LAT(2)) u_lat2 (.clk(clk), .clr(clr), .bus(bus1));
    mem_stage #(.ADDR_W(8), .MEM_LAT(3)) u_lat3 (.clk(clk), .clr(clr), .bus(bus2));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [132:0] mk(input logic [25:0] pj, input logic [31:0] pb,
                                        input logic [31:0] wd, input logic [31:0] alu,
                                        input logic [4:0] wr, input logic j, input logic beq,
                                        input logic mw, input logic mtr, input logic rw,
                                        input logic z);
        return {pj, pb, wd, alu, wr, j, beq, mw, mtr, rw, z};
    endfunction

    // Present one instruction on DUT d (latency d+1) starting just after a negedge,
    // check every cycle until it retires, and leave the bus idle at negedge+1.
    task automatic run_op(input int d, input logic [132:0] ins, input string name);
        int          lat;
        int          n_cyc;
        int          exp_stall;
        int          got_stall;
        logic        memop;
        logic        exp_src;
        logic [31:0] exp_tgt;
        logic [7:0]  idx;
        logic [70:0] exp_out;
        logic [159:0] g;
        lat       = d + 1;
        memop     = ins[2] | ins[3];
        exp_src   = ins[5] | (ins[4] & ins[0]);
        exp_tgt   = ins[5] ? {4'b0000, ins[132:107], 2'b00} : ins[106:75];
        idx       = ins[20:13];
        exp_out   = {32'h0000_0000, ins[42:11], ins[10:6], ins[2], ins[1]};
        if (!ins[3] && ins[2]) exp_out[70:39] = mdl[d][idx];
        exp_stall = (memop && lat > 1) ? lat - 1 : 0;
        n_cyc     = memop ? lat : 1;
        got_stall = 0;
        stim[d]   = ins;
        for (int k = 0; k < n_cyc; k++) begin
            #1;
            if (k == 0) begin
                checks++;
                if (ps[d] !== exp_src || fl[d] !== exp_src || pt[d] !== exp_tgt) begin
                    failures++;
                    $display("FAIL %s redirect lat=%0d got src=%0b flush=%0b tgt=%h want src=%0b tgt=%h",
                             name, lat, ps[d], fl[d], pt[d], exp_src, exp_tgt);
                end
            end else begin
                checks++;
                if (ps[d] !== 1'b0 || fl[d] !== 1'b0 || pt[d] !== 32'h0000_0000) begin
                    failures++;
                    $display("FAIL %s busy_redirect lat=%0d cyc=%0d got src=%0b flush=%0b tgt=%h want 0",
                             name, lat, k, ps[d], fl[d], pt[d]);
                end
                checks++;
                if (outv[d] !== {71{1'b0}}) begin
                    failures++;
                    $display("FAIL %s bubble lat=%0d cyc=%0d got %h want 0", name, lat, k, outv[d]);
                end
            end
            if (st[d] === 1'b1) got_stall++;
            if (k >= 1) begin
                g = {$urandom, $urandom, $urandom, $urandom, $urandom};
                stim[d] = g[132:0];
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (outv[d] !== exp_out) begin
            failures++;
            $display("FAIL %s result lat=%0d got %h want %h", name, lat, outv[d], exp_out);
        end
        checks++;
        if (got_stall != exp_stall) begin
            failures++;
            $display("FAIL %s stall_cycles lat=%0d got %0d want %0d", name, lat, got_stall, exp_stall);
        end
        if (ins[3]) begin
            mdl[d][idx] = ins[74:43];
            vld[d][idx] = 1'b1;
        end
        stim[d] = {133{1'b0}};
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (outv[d] !== {71{1'b0}} || st[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_init lat=%0d got out=%h stall=%0b want 0", d + 1, outv[d], st[d]);
            end
        end
        run_op(1, mk(26'h0, 32'h0, 32'h0, 32'h0000_ABCD, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "reset_pre");
        stim[1] = {133{1'b1}};
        #1 clr = 1'b1;
        #1;
        checks++;
        if (outv[1] !== {71{1'b0}}) begin
            failures++;
            $display("FAIL reset_mid out got %h want 0", outv[1]);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (ps[1] !== 1'b1 || fl[1] !== 1'b1 || st[1] !== 1'b1 || pt[1] !== 32'h0FFF_FFFC) begin
            failures++;
            $display("FAIL reset_after src=%0b flush=%0b stall=%0b tgt=%h want 1 1 1 0ffffffc",
                     ps[1], fl[1], st[1], pt[1]);
        end
        stim[1] = {133{1'b0}};
        @(negedge clk);
        #1;
    endtask

    task automatic test_alu_pass();
        run_op(1, mk(26'h0, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "alu_pass");
        checks++;
        if (outv[1] !== {32'h0000_0000, 32'h0000_1234, 5'd5, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL alu_pass_const got %h", outv[1]);
        end
    endtask

    task automatic test_store_load();
        run_op(1, mk(26'h0, 32'h0, 32'hDEAD_BEEF, 32'h0000_0010, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "sw");
        run_op(1, mk(26'h0, 32'h0, 32'h0, 32'h0000_0013, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lw");
        checks++;
        if (outv[1][70:39] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL lw_data got %h want deadbeef", outv[1][70:39]);
        end
    endtask

    task automatic test_branch();
        run_op(1, mk(26'h0, 32'h0000_0040, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "beq_taken");
        run_op(1, mk(26'h0, 32'h0000_0040, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "beq_not");
        run_op(1, mk(26'h0000100, 32'h0000_0040, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "jump");
        run_op(1, mk(26'h0000020, 32'h0, 32'h1, 32'h0000_0044, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "jump_sw");
    endtask

    task automatic test_latency();
        run_op(0, mk(26'h0, 32'h0, 32'hCAFE_0001, 32'h0000_0020, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "sw_lat1");
        run_op(0, mk(26'h0, 32'h0, 32'h0, 32'h0000_0020, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lw_lat1");
        run_op(2, mk(26'h0, 32'h0, 32'hCAFE_0003, 32'h0000_0020, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "sw_lat3");
        run_op(2, mk(26'h0, 32'h0, 32'h0, 32'h0000_0020, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lw_lat3");
        checks++;
        if (outv[2][70:39] !== 32'hCAFE_0003) begin
            failures++;
            $display("FAIL lw_lat3_data got %h want cafe0003", outv[2][70:39]);
        end
    endtask

    task automatic test_clr_busy();
        run_op(2, mk(26'h0, 32'h0, 32'h0000_0011, 32'h0000_000C, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "sw_prior");
        stim[2] = mk(26'h0, 32'h0, 32'h0000_0055, 32'h0000_000C, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (st[2] !== 1'b1) begin
            failures++;
            $display("FAIL clr_busy_stall got %0b want 1", st[2]);
        end
        #1 clr = 1'b1;
        stim[2] = {133{1'b0}};
        #1;
        clr = 1'b0;
        #1;
        checks++;
        if (st[2] !== 1'b0 || outv[2] !== {71{1'b0}}) begin
            failures++;
            $display("FAIL clr_busy_idle got stall=%0b out=%h want 0", st[2], outv[2]);
        end
        @(negedge clk);
        #1;
        run_op(2, mk(26'h0, 32'h0, 32'h0, 32'h0000_000C, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lw_after_abort");
        checks++;
        if (outv[2][70:39] !== 32'h0000_0011) begin
            failures++;
            $display("FAIL abort_store_kept got %h want 00000011", outv[2][70:39]);
        end
    endtask

    task automatic test_back_to_back();
        logic [132:0] ins;
        logic [31:0]  alu;
        int           kind;
        bit           rare;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 30; n++) begin
                kind = $urandom_range(0, 3);
                alu  = {$urandom_range(0, 7), 2'b00} ^ {$urandom, 2'b00};
                if (kind == 2 && !vld[d][alu[9:2]]) kind = 1;
                rare = ($urandom_range(0, 7) == 0);
                ins  = mk($urandom, $urandom, $urandom, alu, 5'($urandom),
                          (kind == 3 || rare) ? 1'($urandom) : 1'b0,
                          (kind == 3 || rare) ? 1'($urandom) : 1'b0,
                          (kind == 1) ? 1'b1 : 1'b0,
                          (kind == 2) ? 1'b1 : 1'b0,
                          1'($urandom), 1'($urandom));
                run_op(d, ins, "random");
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int d = 0; d < 3; d++) begin
            stim[d] = {133{1'b0}};
            for (int i = 0; i < 256; i++) begin
                mdl[d][i] = 32'h0000_0000;
                vld[d][i] = 1'b0;
            end
        end
        clr = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        clr = 1'b0;
        test_reset();
        test_alu_pass();
        test_store_load();
        test_branch();
        test_latency();
        test_clr_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
